hazard_scoreboard: RTL and testbench

//   Parametrised hazard unit for the 5-stage pipelined RISC-V core (F/D/E/M/W). Adds over the

---
 rtl/hazard_scoreboard.sv | 145 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: forwarding selects, load-use / RAW stalls, branch flushes,
// a sequencer that holds the pipe while a multi-cycle op occupies E, and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LATENCY = 4,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  RegWriteE,
    input  logic                  LoadE,
    input  logic                  MultiCycleE,
    input  logic [1:0]            PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  McStart,
    output logic                  McBusy,
    output logic                  McDone,
    output logic [CNT_W-1:0]      StallCount
);

    localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mcState_t;

    mcState_t        state;
    logic [CW-1:0]   cnt;
    logic            mcLaunch;
    logic            busyNow;
    logic            dataStall;

    function automatic logic match(input logic [REG_ADDR_W-1:0] a,
                                   input logic [REG_ADDR_W-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src,
                                          input logic [REG_ADDR_W-1:0] rdM,
                                          input logic                  wrM,
                                          input logic [REG_ADDR_W-1:0] rdW,
                                          input logic                  wrW);
        if (wrM && match(rdM, src))
            return 2'b10;
        else if (wrW && match(rdW, src))
            return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        mcLaunch  = (state == IDLE) && MultiCycleE;
        busyNow   = mcLaunch || (state == BUSY);
        dataStall = 1'b0;
        if (FWD_EN)
            dataStall = LoadE && (match(RdE, Rs1D) || match(RdE, Rs2D));
        else
            dataStall = (RegWriteE && (match(RdE, Rs1D) || match(RdE, Rs2D))) ||
                        (RegWriteM && (match(RdM, Rs1D) || match(RdM, Rs2D)));

        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        McStart   = 1'b0;
        McBusy    = 1'b0;
        McDone    = 1'b0;

        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            if (FWD_EN) begin
                ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
                ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            end
            // A busy multi-cycle op freezes F/D/E outright; redirects and RAW stalls wait behind it
            if (busyNow) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                FlushM  = 1'b1;
                McStart = mcLaunch;
                McBusy  = 1'b1;
            end else begin
                McDone = (state == DONE);
                if (PCSrcE != 2'b00) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (dataStall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            StallCount <= '0;
        end else begin
            if (StallF)
                StallCount <= satInc(StallCount);
            case (state)
                IDLE: if (MultiCycleE) begin
                    cnt   <= CW'(MC_LATENCY - 2);
                    state <= (MC_LATENCY == 2) ? DONE : BUSY;
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: forwarding and stall-only instances driven in parallel by
// directed vectors, hand-built multi-cycle sequences, and random traffic against a phase model.
module tb_hazard_scoreboard;

    localparam int L      = 4;
    localparam int MAXA   = 65535;
    localparam int MAXB   = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, LoadE, MultiCycleE, RegWriteM, RegWriteW;
    logic [1:0] PCSrcE;

    logic        aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aMcStart, aMcBusy, aMcDone;
    logic [1:0]  aFwdA, aFwdB;
    logic [15:0] aCnt;
    logic        bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bMcStart, bMcBusy, bMcDone;
    logic [1:0]  bFwdA, bFwdB;
    logic [2:0]  bCnt;
    logic [12:0] outA, outB;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .MC_LATENCY(L), .FWD_EN(1'b1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .LoadE(LoadE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(aStallF), .StallD(aStallD), .StallE(aStallE), .FlushD(aFlushD), .FlushE(aFlushE),
        .FlushM(aFlushM), .ForwardAE(aFwdA), .ForwardBE(aFwdB), .McStart(aMcStart),
        .McBusy(aMcBusy), .McDone(aMcDone), .StallCount(aCnt));

    hazard_scoreboard #(.REG_ADDR_W(5), .MC_LATENCY(L), .FWD_EN(1'b0), .CNT_W(3)) dutB (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .LoadE(LoadE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(bStallF), .StallD(bStallD), .StallE(bStallE), .FlushD(bFlushD), .FlushE(bFlushE),
        .FlushM(bFlushM), .ForwardAE(bFwdA), .ForwardBE(bFwdB), .McStart(bMcStart),
        .McBusy(bMcBusy), .McDone(bMcDone), .StallCount(bCnt));

    // Packed order: StallF StallD StallE FlushD FlushE FlushM FwdA[1:0] FwdB[1:0] McStart McBusy McDone
    assign outA = {aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aFwdA, aFwdB,
                   aMcStart, aMcBusy, aMcDone};
    assign outB = {bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bFwdA, bFwdB,
                   bMcStart, bMcBusy, bMcDone};

    typedef struct {
        logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic        regWE, loadE, regWM, regWW;
        logic [1:0]  pcSrc;
        logic [12:0] expA, expB;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [12:0] ex(input logic sF, input logic sD, input logic fD,
                                       input logic fE, input logic [1:0] fa, input logic [1:0] fb);
        return {sF, sD, 1'b0, fD, fE, 1'b0, fa, fb, 3'b000};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clearIn();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; LoadE = 0; MultiCycleE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        clearIn();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: match rule, priority chain, and multi-cycle occupancy expressed as the op's age in E
    function automatic logic m(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 0);
    endfunction

    function automatic logic [12:0] model(input bit fwdEn, input int age);
        logic       ds, sF, sD, sE, fD, fE, fM, st, bz, dn;
        logic [1:0] fa, fb;
        if (rst) return {6'b000110, 4'b0000, 3'b000};
        fa = 2'd0; fb = 2'd0;
        if (fwdEn) begin
            fa = (RegWriteM && m(RdM, Rs1E)) ? 2'd2 : (RegWriteW && m(RdW, Rs1E)) ? 2'd1 : 2'd0;
            fb = (RegWriteM && m(RdM, Rs2E)) ? 2'd2 : (RegWriteW && m(RdW, Rs2E)) ? 2'd1 : 2'd0;
            ds = LoadE && (m(RdE, Rs1D) || m(RdE, Rs2D));
        end else begin
            ds = (RegWriteE && (m(RdE, Rs1D) || m(RdE, Rs2D))) ||
                 (RegWriteM && (m(RdM, Rs1D) || m(RdM, Rs2D)));
        end
        bz = (age >= 0) && (age <= L - 2);
        dn = (age == L - 1);
        st = (age == 0);
        sF = 0; sD = 0; sE = 0; fD = 0; fE = 0; fM = 0;
        if (bz) begin
            sF = 1; sD = 1; sE = 1; fM = 1;
        end else if (PCSrcE != 0) begin
            fD = 1; fE = 1;
        end else if (ds) begin
            sF = 1; sD = 1; fE = 1;
        end
        return {sF, sD, sE, fD, fE, fM, fa, fb, st, bz, dn};
    endfunction

    initial begin
        int age, effAge, cntA, cntB;
        logic [12:0] eA, eB;

        // rs1D rs2D rs1E rs2E rdE rdM rdW regWE loadE regWM regWW pcSrc expA expB
        vecs[0] = '{5, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0, ex(1,1,0,1,0,0), ex(1,1,0,1,0,0)};
        vecs[1] = '{0, 0, 7, 0, 0, 7, 7, 0, 0, 1, 1, 0, ex(0,0,0,0,2,0), ex(0,0,0,0,0,0)};
        vecs[2] = '{0, 0, 7, 3, 0, 3, 7, 0, 0, 1, 1, 0, ex(0,0,0,0,1,2), ex(0,0,0,0,0,0)};
        vecs[3] = '{5, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0, 1, ex(0,0,1,1,0,0), ex(0,0,1,1,0,0)};
        vecs[4] = '{0, 3, 0, 3, 0, 3, 0, 0, 0, 1, 0, 0, ex(0,0,0,0,0,2), ex(1,1,0,1,0,0)};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, ex(0,0,0,0,0,0), ex(0,0,0,0,0,0)};
        vecs[6] = '{0, 0, 4, 4, 0, 4, 4, 0, 0, 0, 1, 0, ex(0,0,0,0,1,1), ex(0,0,0,0,0,0)};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, ex(0,0,1,1,0,0), ex(0,0,1,1,0,0)};
        vecs[8] = '{6, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0), ex(1,1,0,1,0,0)};

        rst = 1'b1;
        clearIn();
        // Reset forces outputs even with a multi-cycle op and hazards presented
        @(negedge clk);
        MultiCycleE = 1; LoadE = 1; RdE = 2; Rs1D = 2; PCSrcE = 1;
        #1;
        check("rstOutA", outA, {6'b000110, 4'b0000, 3'b000});
        check("rstOutB", outB, {6'b000110, 4'b0000, 3'b000});
        @(negedge clk);
        #1;
        check("rstCntA", aCnt, 0);
        check("rstCntB", bCnt, 0);

        doReset();
        for (int i = 0; i < 9; i++) begin
            Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
            RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
            RegWriteE = vecs[i].regWE; LoadE = vecs[i].loadE;
            RegWriteM = vecs[i].regWM; RegWriteW = vecs[i].regWW; PCSrcE = vecs[i].pcSrc;
            #1;
            check($sformatf("vecA%0d", i), outA, vecs[i].expA);
            check($sformatf("vecB%0d", i), outB, vecs[i].expB);
            @(negedge clk);
        end

        // Load-use: one bubble, then the load result comes from W
        doReset();
        LoadE = 1; RegWriteE = 1; RdE = 5; Rs1D = 5; Rs2D = 1;
        #1;
        check("luStall", {aStallF, aStallD, aFlushE}, 3'b111);
        @(negedge clk);
        clearIn(); Rs1D = 5; Rs2D = 1; RdM = 5; RegWriteM = 1;
        #1;
        check("luRelease", {aStallF, aStallD}, 2'b00);
        @(negedge clk);
        clearIn(); Rs1E = 5; Rs2E = 1; RdW = 5; RegWriteW = 1;
        #1;
        check("luFwdW", aFwdA, 2'b01);

        // Stall-only instance: RAW on M stalls D until the producer reaches W
        doReset();
        RdM = 3; RegWriteM = 1; Rs2D = 3; Rs2E = 3;
        #1;
        check("noFwdStall", {bStallF, bStallD, bFwdA, bFwdB}, 6'b110000);
        @(negedge clk);
        RdM = 0; RegWriteM = 0; RdW = 3; RegWriteW = 1;
        #1;
        check("noFwdClear", bStallD, 1'b0);

        // Multi-cycle op with latency 4
        doReset();
        MultiCycleE = 1;
        #1;
        check("mcT0", {aMcStart, aMcBusy, aMcDone, aStallF, aStallE, aFlushM}, 6'b110111);
        for (int t = 1; t < 3; t++) begin
            @(negedge clk);
            #1;
            check($sformatf("mcT%0d", t), {aMcStart, aMcBusy, aMcDone, aStallF, aFlushM}, 5'b01011);
        end
        @(negedge clk);
        #1;
        check("mcT3", {aMcStart, aMcBusy, aMcDone, aStallF, aFlushM}, 5'b00100);
        check("mcCnt3", aCnt, 3);
        @(negedge clk);
        MultiCycleE = 0;
        #1;
        check("mcT4", {aMcBusy, aMcDone}, 2'b00);
        check("mcCntHold", aCnt, 3);

        // Reset in the middle of BUSY: no McDone afterwards
        doReset();
        MultiCycleE = 1;
        @(negedge clk);
        #1;
        check("rbBusy", aMcBusy, 1'b1);
        @(negedge clk);
        rst = 1;
        #1;
        check("rbForced", {aMcBusy, aStallF, aFlushD}, 3'b001);
        @(negedge clk);
        rst = 0; MultiCycleE = 0;
        #1;
        check("rbIdle", {aMcBusy, aMcDone}, 2'b00);
        check("rbCnt", aCnt, 0);
        @(negedge clk);
        #1;
        check("rbNoDone", aMcDone, 1'b0);

        // Random traffic against the reference model
        doReset();
        age = -1; cntA = 0; cntB = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 149) == 0);
            MultiCycleE = ($urandom_range(0, 5) == 0);
            LoadE       = $urandom_range(0, 1);
            RegWriteE   = $urandom_range(0, 1);
            RegWriteM   = $urandom_range(0, 1);
            RegWriteW   = $urandom_range(0, 1);
            PCSrcE      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            #1;
            effAge = (age < 0 && MultiCycleE && !rst) ? 0 : age;
            eA = model(1'b1, effAge);
            eB = model(1'b0, effAge);
            check("randA", outA, eA);
            check("randB", outB, eB);
            check("randCntA", aCnt, cntA);
            check("randCntB", bCnt, cntB);
            if (rst) begin
                age = -1; cntA = 0; cntB = 0;
            end else begin
                age = (effAge >= 0 && effAge < L - 1) ? effAge + 1 : -1;
                if (eA[12] && cntA < MAXA) cntA++;
                if (eB[12] && cntB < MAXB) cntB++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
